// File: rtl/eda_region_ctrl.sv
// eda_region_ctrl: flood-fill sequencer for imregionalmax, BFS over equal-valued plateaus around eda_compare.
// Build option EDA_REGION_STATS_EN adds o_region_size / o_region_count outputs.

module eda_region_nbr #(
    parameter int M          = 16,
    parameter int N          = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int B          = 0
) (
    input  int                    i_row,
    input  int                    i_col,
    output logic                  o_valid,
    output logic [ADDR_WIDTH-1:0] o_addr
);
    // Bit b skips the window centre (k = 4).
    localparam int K  = (B < 4) ? B : B + 1;
    localparam int DR = K / 3 - 1;
    localparam int DC = K % 3 - 1;

    int w_r, w_c;

    always_comb begin
        w_r     = i_row + DR;
        w_c     = i_col + DC;
        o_valid = (w_r >= 0) && (w_r < M) && (w_c >= 0) && (w_c < N);
        o_addr  = o_valid ? ADDR_WIDTH'(w_r * N + w_c) : '0;
    end
endmodule

module eda_region_ctrl #(
    parameter int M          = 16,
    parameter int N          = 16,
    parameter int ADDR_WIDTH = $clog2(M * N),
    parameter int FIFO_DEPTH = M * N
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_win_req,
    output logic [ADDR_WIDTH-1:0] o_win_addr,
    input  logic                  i_win_valid,
    output logic                  o_new_pixel,
    input  logic                  i_compare_out,
    input  logic [7:0]            i_push_positions,
    output logic [7:0]            o_neigh_addr_valid,
    output logic [7:0]            o_iterated_idx,
    output logic                  o_member_valid,
    output logic [ADDR_WIDTH-1:0] o_member_addr,
    output logic                  o_region_done,
    output logic                  o_region_is_max,
`ifdef EDA_REGION_STATS_EN
    output logic [ADDR_WIDTH:0]   o_region_size,
    output logic [ADDR_WIDTH:0]   o_region_count,
`endif
    output logic                  o_ovf_err
);
    localparam int NPIX = M * N;
    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH + 1)'(NPIX);

    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_FETCH, S_EVAL, S_CAPT, S_DRAIN} state_t;

    state_t                r_state;
    logic [NPIX-1:0]       r_visited;
    logic [ADDR_WIDTH:0]   r_scan;
    logic                  r_is_max;
    logic [7:0]            r_pending;
    logic [ADDR_WIDTH-1:0] r_fifo [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]         r_fcnt;
`ifdef EDA_REGION_STATS_EN
    logic [ADDR_WIDTH:0]   r_size;
`endif

    int                          w_row, w_col;
    logic [7:0]                  w_nav, w_iter;
    logic [7:0][ADDR_WIDTH-1:0]  w_nbr_addr;
    logic [2:0]                  w_sel;
    logic                        w_full, w_empty, w_push;

    assign w_row = int'(o_win_addr) / N;
    assign w_col = int'(o_win_addr) % N;

    for (genvar b = 0; b < 8; b++) begin : g_nbr
        eda_region_nbr #(.M(M), .N(N), .ADDR_WIDTH(ADDR_WIDTH), .B(b)) u_nbr (
            .i_row   (w_row),
            .i_col   (w_col),
            .o_valid (w_nav[b]),
            .o_addr  (w_nbr_addr[b])
        );
        assign w_iter[b] = w_nav[b] & r_visited[w_nbr_addr[b]];
    end

    assign o_neigh_addr_valid = w_nav;
    assign o_iterated_idx     = w_iter;

    always_comb begin
        w_sel = '0;
        for (int b = 7; b >= 0; b--)
            if (r_pending[b]) w_sel = 3'(b);
    end

    assign w_full  = (r_fcnt == CW'(FIFO_DEPTH));
    assign w_empty = (r_fcnt == '0);
    assign w_push  = (r_state == S_DRAIN) && (|r_pending) && !w_full;

    // Queue storage carries no reset; pointers and count define its contents.
    always_ff @(posedge clk)
        if (w_push) r_fifo[r_wr_ptr] <= w_nbr_addr[w_sel];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= S_IDLE;
            r_visited       <= '0;
            r_scan          <= '0;
            r_is_max        <= 1'b0;
            r_pending       <= '0;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_fcnt          <= '0;
            o_busy          <= 1'b0;
            o_done          <= 1'b0;
            o_win_req       <= 1'b0;
            o_win_addr      <= '0;
            o_new_pixel     <= 1'b0;
            o_member_valid  <= 1'b0;
            o_member_addr   <= '0;
            o_region_done   <= 1'b0;
            o_region_is_max <= 1'b0;
            o_ovf_err       <= 1'b0;
`ifdef EDA_REGION_STATS_EN
            r_size          <= '0;
            o_region_size   <= '0;
            o_region_count  <= '0;
`endif
        end else begin
            o_done          <= 1'b0;
            o_new_pixel     <= 1'b0;
            o_member_valid  <= 1'b0;
            o_region_done   <= 1'b0;
            o_region_is_max <= 1'b0;
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_visited <= '0;
                    r_scan    <= '0;
                    r_pending <= '0;
                    r_wr_ptr  <= '0;
                    r_rd_ptr  <= '0;
                    r_fcnt    <= '0;
                    o_busy    <= 1'b1;
`ifdef EDA_REGION_STATS_EN
                    o_region_count <= '0;
`endif
                    r_state   <= S_SCAN;
                end
                S_SCAN: begin
                    if (r_scan == LAST) begin
                        o_done  <= 1'b1;
                        o_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_visited[r_scan[ADDR_WIDTH-1:0]]) begin
                        r_scan <= r_scan + 1'b1;
                    end else begin
                        r_visited[r_scan[ADDR_WIDTH-1:0]] <= 1'b1;
                        o_win_addr     <= r_scan[ADDR_WIDTH-1:0];
                        o_member_addr  <= r_scan[ADDR_WIDTH-1:0];
                        o_member_valid <= 1'b1;
                        o_win_req      <= 1'b1;
                        r_is_max       <= 1'b1;
`ifdef EDA_REGION_STATS_EN
                        r_size         <= (ADDR_WIDTH + 1)'(1);
`endif
                        r_state        <= S_FETCH;
                    end
                end
                S_FETCH: if (i_win_valid) begin
                    o_win_req   <= 1'b0;
                    o_new_pixel <= 1'b1;
                    r_state     <= S_EVAL;
                end
                S_EVAL: begin
                    r_is_max <= r_is_max & i_compare_out;
                    r_state  <= S_CAPT;
                end
                S_CAPT: begin
                    // Marking at capture guarantees each address is queued at most once.
                    r_pending <= i_push_positions & w_nav;
                    for (int b = 0; b < 8; b++)
                        if (i_push_positions[b] && w_nav[b]) r_visited[w_nbr_addr[b]] <= 1'b1;
                    r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (|r_pending) begin
                        r_pending[w_sel] <= 1'b0;
                        o_member_valid   <= 1'b1;
                        o_member_addr    <= w_nbr_addr[w_sel];
`ifdef EDA_REGION_STATS_EN
                        r_size           <= r_size + 1'b1;
`endif
                        if (w_full) begin
                            o_ovf_err <= 1'b1;
                        end else begin
                            r_wr_ptr <= (r_wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
                            r_fcnt   <= r_fcnt + 1'b1;
                        end
                    end else if (!w_empty) begin
                        o_win_addr <= r_fifo[r_rd_ptr];
                        r_rd_ptr   <= (r_rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
                        r_fcnt     <= r_fcnt - 1'b1;
                        o_win_req  <= 1'b1;
                        r_state    <= S_FETCH;
                    end else begin
                        o_region_done   <= 1'b1;
                        o_region_is_max <= r_is_max;
`ifdef EDA_REGION_STATS_EN
                        o_region_size   <= r_size;
                        o_region_count  <= o_region_count + 1'b1;
`endif
                        r_scan          <= r_scan + 1'b1;
                        r_state         <= S_SCAN;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_eda_region_ctrl.sv
// Bench for eda_region_ctrl on a 4x4 image: eda_compare model, window responder, BFS scoreboard.
module tb_eda_region_ctrl;
    localparam int M = 4, N = 4, AW = 4;

    logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, win_valid = 1'b0, compare_out = 1'b0;
    logic [7:0] push_positions = 8'h00;
    logic busy, done, win_req, new_pixel, member_valid, region_done, region_is_max, ovf_err;
    logic [AW-1:0] win_addr, member_addr;
    logic [7:0] nav, iter;
`ifdef EDA_REGION_STATS_EN
    logic [AW:0] region_size, region_count;
`endif

    eda_region_ctrl #(.M(M), .N(N)) dut (
        .clk(clk), .reset_n(reset_n), .i_start(start), .o_busy(busy), .o_done(done),
        .o_win_req(win_req), .o_win_addr(win_addr), .i_win_valid(win_valid),
        .o_new_pixel(new_pixel), .i_compare_out(compare_out), .i_push_positions(push_positions),
        .o_neigh_addr_valid(nav), .o_iterated_idx(iter), .o_member_valid(member_valid),
        .o_member_addr(member_addr), .o_region_done(region_done), .o_region_is_max(region_is_max),
`ifdef EDA_REGION_STATS_EN
        .o_region_size(region_size), .o_region_count(region_count),
`endif
        .o_ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    int img [16];
    int checks = 0, failures = 0;
    int win_delay = 0;
    bit mon_en = 1'b0;
    int exp_mem [$];
    bit exp_reg [$];
    bit reg_log [$];
    int member_cnt [16];
    int done_cnt = 0, win_idx = 0, stab_err = 0;
    logic [7:0] nav1, it1, nav2, it2;
    logic [AW-1:0] wa1, wa2, prev_addr;
    logic prev_req = 1'b0;
    int mon_e;
    bit mon_r;

    function automatic int nbr(int a, int b);
        int k, r, c;
        k = (b < 4) ? b : b + 1;
        r = a / N + k / 3 - 1;
        c = a % N + k % 3 - 1;
        if (r < 0 || r >= M || c < 0 || c >= N) return -1;
        return r * N + c;
    endfunction

    function automatic bit model_cmp(int a);
        bit ok = 1'b1;
        for (int b = 0; b < 8; b++)
            if (nbr(a, b) >= 0 && img[a] < img[nbr(a, b)]) ok = 1'b0;
        return ok;
    endfunction

    function automatic logic [7:0] model_eq(int a);
        logic [7:0] m = 8'h00;
        for (int b = 0; b < 8; b++)
            if (nbr(a, b) >= 0 && img[nbr(a, b)] == img[a]) m[b] = 1'b1;
        return m;
    endfunction

    // Reference BFS: seeds in raster order, neighbours in bit order, FIFO visiting order.
    task automatic build_expected();
        bit vis [16];
        int q [$];
        int c, n;
        bit ism;
        for (int i = 0; i < 16; i++) vis[i] = 1'b0;
        for (int s = 0; s < 16; s++) begin
            if (!vis[s]) begin
                vis[s] = 1'b1;
                exp_mem.push_back(s);
                ism = 1'b1;
                q.push_back(s);
                while (q.size() > 0) begin
                    c = q.pop_front();
                    ism = ism & model_cmp(c);
                    for (int b = 0; b < 8; b++) begin
                        n = nbr(c, b);
                        if (n >= 0 && !vis[n] && img[n] == img[c]) begin
                            vis[n] = 1'b1;
                            exp_mem.push_back(n);
                            q.push_back(n);
                        end
                    end
                end
                exp_reg.push_back(ism);
            end
        end
    endtask

    // eda_compare model and window responder.
    initial begin : responder
        int wait_cnt;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            compare_out    = model_cmp(int'(win_addr));
            push_positions = model_eq(int'(win_addr)) & nav & ~iter;
            if (!reset_n) begin
                win_valid = 1'b0;
                wait_cnt  = 0;
            end else if (win_valid) begin
                win_valid = 1'b0;
            end else if (win_req) begin
                if (wait_cnt >= win_delay) begin
                    win_valid = 1'b1;
                    wait_cnt  = 0;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en && reset_n) begin
            if (member_valid) begin
                checks++;
                member_cnt[member_addr]++;
                if (exp_mem.size() == 0) begin
                    failures++;
                    $display("FAIL member_extra got=%0d expected=none", member_addr);
                end else begin
                    mon_e = exp_mem.pop_front();
                    if (int'(member_addr) !== mon_e) begin
                        failures++;
                        $display("FAIL member_addr got=%0d expected=%0d", member_addr, mon_e);
                    end
                end
            end
            if (region_done) begin
                checks++;
                reg_log.push_back(region_is_max);
                if (exp_reg.size() == 0) begin
                    failures++;
                    $display("FAIL region_extra got=%0b expected=none", region_is_max);
                end else begin
                    mon_r = exp_reg.pop_front();
                    if (region_is_max !== mon_r) begin
                        failures++;
                        $display("FAIL region_is_max got=%0b expected=%0b", region_is_max, mon_r);
                    end
                end
            end
            if (done) done_cnt++;
            if (win_req && !prev_req) begin
                win_idx++;
                if (win_idx == 1) begin nav1 = nav; it1 = iter; wa1 = win_addr; end
                if (win_idx == 2) begin nav2 = nav; it2 = iter; wa2 = win_addr; end
            end
            if (win_req && prev_req && win_addr !== prev_addr) stab_err++;
            if (win_req && new_pixel) stab_err++;
        end
        prev_req  = win_req;
        prev_addr = win_addr;
    end

    task automatic run_frame(input string name, input bit dup_start);
        int d0, bad;
        bit got;
        build_expected();
        reg_log.delete();
        for (int i = 0; i < 16; i++) member_cnt[i] = 0;
        win_idx = 0;
        d0 = done_cnt;
        got = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk);
            start = (dup_start && t == 10);
            if (done_cnt != d0) begin got = 1'b1; break; end
        end
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (!got) begin failures++; $display("FAIL %s_done_timeout got=0 expected=1", name); end
        checks++;
        if (exp_mem.size() != 0 || exp_reg.size() != 0) begin
            failures++;
            $display("FAIL %s_leftover got=%0d/%0d expected=0/0", name, exp_mem.size(), exp_reg.size());
        end
        checks++;
        if ({busy, ovf_err} !== 2'b00) begin
            failures++;
            $display("FAIL %s_busy_ovf got=%b expected=00", name, {busy, ovf_err});
        end
        bad = 0;
        for (int i = 0; i < 16; i++) if (member_cnt[i] != 1) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL %s_member_once got=%0d expected=0", name, bad); end
        exp_mem.delete();
        exp_reg.delete();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, win_req, new_pixel, member_valid, region_done, region_is_max, ovf_err} !== 8'h00) begin
            failures++;
            $display("FAIL reset_flags got=%b expected=00000000",
                     {busy, done, win_req, new_pixel, member_valid, region_done, region_is_max, ovf_err});
        end
        checks++;
        if ({win_addr, member_addr} !== 8'h00) begin
            failures++;
            $display("FAIL reset_addr got=%h expected=00", {win_addr, member_addr});
        end
        reset_n = 1'b1;
        mon_en  = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_flat();
        for (int i = 0; i < 16; i++) img[i] = 7;
        run_frame("flat", 1'b0);
        checks++;
        if (reg_log.size() != 1 || reg_log[0] !== 1'b1) begin
            failures++;
            $display("FAIL flat_regions got=%0d expected=1 (is_max 1)", reg_log.size());
        end
        checks++;
        if ({wa1, nav1, it1} !== {4'd0, 8'hD0, 8'h00}) begin
            failures++;
            $display("FAIL corner_window got=%h expected=%h", {wa1, nav1, it1}, {4'd0, 8'hD0, 8'h00});
        end
        checks++;
        if ({wa2, nav2, it2} !== {4'd1, 8'hF8, 8'h68}) begin
            failures++;
            $display("FAIL second_window got=%h expected=%h", {wa2, nav2, it2}, {4'd1, 8'hF8, 8'h68});
        end
    endtask

    task automatic test_peak();
        for (int i = 0; i < 16; i++) img[i] = 3;
        img[5] = 9;
        run_frame("peak", 1'b0);
        checks++;
        if (reg_log.size() != 2 || reg_log[0] !== 1'b0 || reg_log[1] !== 1'b1) begin
            failures++;
            $display("FAIL peak_regions got=%0d expected=2 (is_max 0 then 1)", reg_log.size());
        end
    endtask

    task automatic test_plateau();
        for (int i = 0; i < 16; i++) img[i] = 2;
        img[0] = 5;
        img[1] = 5;
        run_frame("plateau", 1'b0);
        checks++;
        if (reg_log.size() != 2 || reg_log[0] !== 1'b1 || reg_log[1] !== 1'b0) begin
            failures++;
            $display("FAIL plateau_regions got=%0d expected=2 (is_max 1 then 0)", reg_log.size());
        end
    endtask

    task automatic test_win_delay();
        for (int i = 0; i < 16; i++) img[i] = int'($urandom_range(0, 3));
        win_delay = 5;
        stab_err  = 0;
        run_frame("delay", 1'b0);
        win_delay = 0;
        checks++;
        if (stab_err != 0) begin failures++; $display("FAIL delay_stability got=%0d expected=0", stab_err); end
        checks++;
        if ({wa1, nav1} !== {4'd0, 8'hD0}) begin
            failures++;
            $display("FAIL delay_corner got=%h expected=%h", {wa1, nav1}, {4'd0, 8'hD0});
        end
    endtask

    task automatic test_reset_drain();
        bit hit;
        for (int i = 0; i < 16; i++) img[i] = 7;
        build_expected();
        hit = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (member_valid && member_addr == 4'd1) begin hit = 1'b1; break; end
        end
        checks++;
        if (!hit) begin failures++; $display("FAIL drain_reach got=0 expected=1"); end
        mon_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, win_req, new_pixel, member_valid, region_done, done} !== 6'b0) begin
            failures++;
            $display("FAIL drain_reset got=%b expected=000000",
                     {busy, win_req, new_pixel, member_valid, region_done, done});
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        exp_mem.delete();
        exp_reg.delete();
        mon_en = 1'b1;
        for (int i = 0; i < 16; i++) img[i] = int'($urandom_range(0, 2));
        run_frame("after_reset", 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 16; i++) img[i] = int'($urandom_range(0, 4));
            win_delay = int'($urandom_range(0, 2));
            run_frame("b2b", f == 1);
        end
        win_delay = 0;
    endtask

    initial begin
        test_reset();
        test_flat();
        test_peak();
        test_plateau();
        test_win_delay();
        test_reset_drain();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
